// File: rtl/ft245_cmd_rx.sv
// FT245 host-to-FPGA receive path: fetches bytes with the RXF#/RD# handshake,
// deframes 7-byte command packets and offers a checksummed command word.
module ft245_cmd_rx #(
    parameter int          RD_LOW_CYC   = 5,
    parameter int          RD_HIGH_CYC  = 11,
    parameter int          BYTE_TIMEOUT = 800000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXF,
    input  logic [7:0]  DATA_IN,
    input  logic        BUS_EN,
    output logic        RD,
    output logic        RD_BUSY,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [1:0]  CMD_TGT,
    output logic [31:0] CMD_DATA,
    output logic        ERR_CSUM,
    output logic        ERR_TIMEOUT,
    output logic [1:0]  dbg_state
);

    // Handshake: a command transfers on any clock where CMD_VALID and CMD_READY
    // are both high; CMD_TGT/CMD_DATA hold steady while CMD_VALID waits.

    localparam int CMAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(BYTE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_LOW  = 2'd1,
        S_RD_HIGH = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t         state;
    logic           rxf_meta;
    logic           rxf_s;
    logic [CW-1:0]  cyc;
    logic [TW-1:0]  to_cnt;
    logic [2:0]     idx;
    logic [7:0]     rx_byte;
    logic [7:0]     hdr;
    logic [7:0]     xacc;
    logic [31:0]    payload;
    logic           frame_ok;

    assign dbg_state = state;

    // Checksum byte matches and the target is not the reserved code.
    assign frame_ok = (idx == 3'd6) && (rx_byte == xacc) && (hdr[1:0] != 2'd3);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rxf_meta <= 1'b1;
            rxf_s    <= 1'b1;
        end else begin
            rxf_meta <= RXF;
            rxf_s    <= rxf_meta;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            RD          <= 1'b1;
            RD_BUSY     <= 1'b0;
            CMD_VALID   <= 1'b0;
            CMD_TGT     <= 2'd0;
            CMD_DATA    <= 32'd0;
            ERR_CSUM    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            cyc         <= '0;
            to_cnt      <= '0;
            idx         <= 3'd0;
            rx_byte     <= 8'd0;
            hdr         <= 8'd0;
            xacc        <= 8'd0;
            payload     <= 32'd0;
        end else begin
            ERR_CSUM    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            if (CMD_VALID && CMD_READY)
                CMD_VALID <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Inter-byte timeout only counts while a frame is open.
                    if (idx != 3'd0) begin
                        if (to_cnt == TW'(BYTE_TIMEOUT - 1)) begin
                            ERR_TIMEOUT <= 1'b1;
                            idx         <= 3'd0;
                            to_cnt      <= TW'(BYTE_TIMEOUT);
                        end else if (to_cnt < TW'(BYTE_TIMEOUT - 1)) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    if (!rxf_s && BUS_EN) begin
                        state   <= S_RD_LOW;
                        RD      <= 1'b0;
                        RD_BUSY <= 1'b1;
                        cyc     <= '0;
                    end
                end

                S_RD_LOW: begin
                    if (cyc == CW'(RD_LOW_CYC - 1)) begin
                        rx_byte <= DATA_IN;
                        RD      <= 1'b1;
                        cyc     <= '0;
                        state   <= S_RD_HIGH;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                S_RD_HIGH: begin
                    if (cyc == '0) begin
                        to_cnt <= '0;
                        case (idx)
                            3'd0: if (rx_byte == SYNC_BYTE) idx <= 3'd1;
                            3'd1: begin
                                hdr  <= rx_byte;
                                xacc <= rx_byte;
                                idx  <= 3'd2;
                            end
                            3'd6: begin
                                if (frame_ok) begin
                                    CMD_TGT   <= hdr[1:0];
                                    CMD_DATA  <= payload;
                                    CMD_VALID <= 1'b1;
                                end else begin
                                    ERR_CSUM <= 1'b1;
                                end
                                idx <= 3'd0;
                            end
                            default: begin
                                payload <= {payload[23:0], rx_byte};
                                xacc    <= xacc ^ rx_byte;
                                idx     <= idx + 3'd1;
                            end
                        endcase
                    end
                    if (cyc == CW'(RD_HIGH_CYC - 1)) begin
                        RD_BUSY <= 1'b0;
                        cyc     <= '0;
                        // Park in DELIVER while a command is still unaccepted.
                        if ((cyc == '0 && frame_ok) || (CMD_VALID && !CMD_READY))
                            state <= S_DELIVER;
                        else
                            state <= S_IDLE;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end

                S_DELIVER: begin
                    if (CMD_READY)
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_cmd_rx.sv
// Directed bench for ft245_cmd_rx: FT245 FIFO model, command scoreboard and
// handshake-timing monitor.
module tb_ft245_cmd_rx;

    localparam int LOW_CYC  = 5;
    localparam int HIGH_CYC = 11;
    localparam int TB_TMO   = 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        RXF = 1'b1;
    logic [7:0]  DATA_IN = 8'h5A;
    logic        BUS_EN = 1'b0;
    logic        CMD_READY = 1'b0;
    logic        RD;
    logic        RD_BUSY;
    logic        CMD_VALID;
    logic [1:0]  CMD_TGT;
    logic [31:0] CMD_DATA;
    logic        ERR_CSUM;
    logic        ERR_TIMEOUT;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  host_q[$];
    logic [33:0] exp_q[$];
    logic        rxf_en = 1'b0;

    int  n_falls  = 0;
    int  n_deliv  = 0;
    int  csum_cyc = 0;
    int  to_cyc   = 0;
    int  lowc     = 0;
    int  highc    = 0;
    int  fall_age = 0;
    int  idle_age = 0;
    bit  have_rise = 1'b0;
    logic rd_prev = 1'b1;
    logic v_prev = 1'b0;
    logic a_prev = 1'b0;
    logic busy_prev = 1'b0;
    logic [33:0] held;

    ft245_cmd_rx #(
        .RD_LOW_CYC  (LOW_CYC),
        .RD_HIGH_CYC (HIGH_CYC),
        .BYTE_TIMEOUT(TB_TMO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXF        (RXF),
        .DATA_IN    (DATA_IN),
        .BUS_EN     (BUS_EN),
        .RD         (RD),
        .RD_BUSY    (RD_BUSY),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_TGT    (CMD_TGT),
        .CMD_DATA   (CMD_DATA),
        .ERR_CSUM   (ERR_CSUM),
        .ERR_TIMEOUT(ERR_TIMEOUT),
        .dbg_state  (dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [31:0] d,
                              input logic [7:0] cs, input bit good);
        host_q.push_back(8'hA5);
        host_q.push_back(hdr);
        host_q.push_back(d[31:24]);
        host_q.push_back(d[23:16]);
        host_q.push_back(d[15:8]);
        host_q.push_back(d[7:0]);
        host_q.push_back(cs);
        if (good) exp_q.push_back({hdr[1:0], d});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (n < 3000 && !(host_q.size() == 0 && !RD_BUSY && !CMD_VALID)) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_drained"}, 64'(n < 3000), 64'd1);
        repeat (4) @(negedge CLK);
    endtask

    // FT245 FIFO model plus bus/handshake monitor, all sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            lowc = 0;
            highc = 0;
            have_rise = 1'b0;
            v_prev = 1'b0;
            a_prev = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (RD == 1'b0) begin
                if (rd_prev) begin
                    n_falls++;
                    fall_age = 0;
                    chk("no_read_while_valid", 64'(CMD_VALID), 64'd0);
                    if (have_rise) chk("rd_high_min", 64'(highc >= HIGH_CYC), 64'd1);
                end else begin
                    fall_age++;
                end
                lowc++;
            end else begin
                fall_age++;
                if (!rd_prev) begin
                    chk("rd_low_cycles", 64'(lowc), 64'(LOW_CYC));
                    if (host_q.size() > 0) void'(host_q.pop_front());
                    have_rise = 1'b1;
                    highc = 0;
                    lowc = 0;
                end
                highc++;
            end

            if (busy_prev && !RD_BUSY) idle_age = 0;
            else idle_age++;

            if (CMD_VALID && !v_prev)
                chk("valid_latency", 64'(fall_age), 64'(LOW_CYC + 1));
            if (CMD_VALID && v_prev && !a_prev)
                chk("cmd_stable", {30'd0, CMD_TGT, CMD_DATA}, {30'd0, held});
            if (CMD_VALID && CMD_READY) begin
                chk("cmd_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0)
                    chk("cmd_word", {30'd0, CMD_TGT, CMD_DATA}, {30'd0, exp_q.pop_front()});
                n_deliv++;
            end
            if (ERR_CSUM) csum_cyc++;
            if (ERR_TIMEOUT) begin
                to_cyc++;
                chk("timeout_idle_clocks", 64'(idle_age), 64'(TB_TMO));
            end
            held = {CMD_TGT, CMD_DATA};
            v_prev = CMD_VALID;
            a_prev = CMD_VALID && CMD_READY;
            busy_prev = RD_BUSY;
        end
        rd_prev = RD;
        RXF = !(rxf_en && host_q.size() > 0);
        // Bus carries the byte only on the final low cycle.
        if (host_q.size() > 0)
            DATA_IN = (RD == 1'b0 && lowc == LOW_CYC) ? host_q[0] : ~host_q[0];
        else
            DATA_IN = 8'h5A;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0, t0, f0, n;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_rd", 64'(RD), 64'd1);
        chk("rst_rd_busy", 64'(RD_BUSY), 64'd0);
        chk("rst_valid", 64'(CMD_VALID), 64'd0);
        chk("rst_tgt", 64'(CMD_TGT), 64'd0);
        chk("rst_data", 64'(CMD_DATA), 64'd0);
        chk("rst_errs", 64'({ERR_CSUM, ERR_TIMEOUT}), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'd0);
        RST = 1'b1;
        BUS_EN = 1'b1;
        CMD_READY = 1'b1;
        rxf_en = 1'b1;
        repeat (3) @(negedge CLK);

        // Basic good frame.
        d0 = n_deliv;
        push_frame(8'h00, 32'h12345678, 8'h08, 1'b1);
        wait_drain("good1");
        chk("good1_count", 64'(n_deliv - d0), 64'd1);

        // Leading garbage is hunted past.
        d0 = n_deliv;
        host_q.push_back(8'h00);
        host_q.push_back(8'hFF);
        push_frame(8'h01, 32'h0000002A, 8'h2B, 1'b1);
        wait_drain("garbage");
        chk("garbage_count", 64'(n_deliv - d0), 64'd1);
        chk("garbage_no_err", 64'(csum_cyc + to_cyc), 64'd0);

        // Bad checksum, reserved target, then a good frame.
        d0 = n_deliv;
        push_frame(8'h02, 32'h00000001, 8'h00, 1'b0);
        wait_drain("badcs");
        chk("badcs_pulse", 64'(csum_cyc), 64'd1);
        chk("badcs_no_cmd", 64'(n_deliv - d0), 64'd0);
        push_frame(8'h03, 32'h00000000, 8'h03, 1'b0);
        wait_drain("rsvd");
        chk("rsvd_pulse", 64'(csum_cyc), 64'd2);
        push_frame(8'h02, 32'hDEADBEEF, 8'h20, 1'b1);
        wait_drain("after_bad");
        chk("after_bad_count", 64'(n_deliv - d0), 64'd1);

        // Backpressure with more data waiting in the FIFO.
        d0 = n_deliv;
        CMD_READY = 1'b0;
        push_frame(8'h00, 32'hCAFE0001, 8'h35, 1'b1);
        push_frame(8'h01, 32'h11223344, 8'h45, 1'b1);
        n = 0;
        while (n < 1000 && !CMD_VALID) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_valid_seen", 64'(n < 1000), 64'd1);
        repeat (12) @(negedge CLK);
        f0 = n_falls;
        repeat (50) @(negedge CLK);
        chk("bp_no_reads", 64'(n_falls - f0), 64'd0);
        chk("bp_valid_held", 64'(CMD_VALID), 64'd1);
        chk("bp_rd_high", 64'(RD), 64'd1);
        CMD_READY = 1'b1;
        wait_drain("bp");
        chk("bp_count", 64'(n_deliv - d0), 64'd2);

        // Inter-byte timeout mid-frame.
        d0 = n_deliv;
        c0 = csum_cyc;
        host_q.push_back(8'hA5);
        host_q.push_back(8'h00);
        host_q.push_back(8'h12);
        wait_drain("tmo_bytes");
        t0 = to_cyc;
        repeat (120) @(negedge CLK);
        chk("tmo_pulse", 64'(to_cyc - t0), 64'd1);
        chk("tmo_no_csum", 64'(csum_cyc - c0), 64'd0);
        push_frame(8'h00, 32'h12345678, 8'h08, 1'b1);
        wait_drain("after_tmo");
        chk("after_tmo_count", 64'(n_deliv - d0), 64'd1);

        // Bus not granted: no reads until BUS_EN returns.
        d0 = n_deliv;
        BUS_EN = 1'b0;
        f0 = n_falls;
        push_frame(8'h01, 32'hA5A5A5A5, 8'h01, 1'b1);
        repeat (60) @(negedge CLK);
        chk("busen_no_reads", 64'(n_falls - f0), 64'd0);
        chk("busen_rd_high", 64'(RD), 64'd1);
        BUS_EN = 1'b1;
        wait_drain("busen");
        chk("busen_count", 64'(n_deliv - d0), 64'd1);

        // Reset in the middle of a byte read.
        d0 = n_deliv;
        f0 = n_falls;
        push_frame(8'h00, 32'hABCDEF01, 8'h00, 1'b0);
        n = 0;
        while (n < 1000 && n_falls < f0 + 3) begin
            @(negedge CLK);
            n++;
        end
        chk("rst_mid_reached", 64'(n < 1000), 64'd1);
        repeat (2) @(negedge CLK);
        chk("rst_mid_rd_low", 64'(RD), 64'd0);
        #2;
        rxf_en = 1'b0;
        RST = 1'b0;
        #1;
        chk("rst_mid_rd", 64'(RD), 64'd1);
        chk("rst_mid_busy", 64'(RD_BUSY), 64'd0);
        chk("rst_mid_state", 64'(dbg_state), 64'd0);
        repeat (3) @(negedge CLK);
        host_q.delete();
        RST = 1'b1;
        rxf_en = 1'b1;
        repeat (5) @(negedge CLK);
        push_frame(8'h02, 32'h00000005, 8'h07, 1'b1);
        wait_drain("after_rst");
        chk("after_rst_count", 64'(n_deliv - d0), 64'd1);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
